// File: rtl/hartslag_generator_if.sv
// Heart-rate pulse interface: the generator drives the pulse side, the
// counter or bench drives enable and requested rate.
interface hartslag_generator_if;
    logic       Enable;
    logic [7:0] Freq;
    logic       Puls;
    logic [7:0] Tel;
    logic       Venster;

    modport master (input Enable, Freq, output Puls, Tel, Venster);
    modport slave  (output Enable, Freq, input Puls, Tel, Venster);
endinterface

// File: rtl/hartslag_generator.sv
// Synthetic heartbeat source: Freq evenly spaced pulses per 2^WINDOW-cycle
// window, period derived by a bit-serial restoring divider.
module hartslag_generator #(
    parameter int unsigned WINDOW    = 28,
    parameter int unsigned PULSE_LEN = 4
) (
    input  logic                 CLK,
    input  logic                 Reset,
    hartslag_generator_if.master hs
);
    localparam int unsigned       DW    = (WINDOW > 8) ? WINDOW : 8;
    localparam logic [WINDOW-1:0] W_FIN = WINDOW'(WINDOW + 1);
    localparam logic [WINDOW-1:0] ONE   = WINDOW'(1);
    localparam logic [WINDOW-1:0] TWO   = WINDOW'(2);
    localparam logic [WINDOW-1:0] PLEN  = WINDOW'(PULSE_LEN);

    typedef enum logic [1:0] {IDLE, DELEN, ACTIEF, WACHT} state_t;

    state_t            state;
    logic [WINDOW-1:0] w;
    logic [WINDOW-1:0] q;
    logic [WINDOW-1:0] p;
    logic [WINDOW-1:0] ph;
    logic [DW-1:0]     r;
    logic [7:0]        f;
    logic [7:0]        tel;
    logic              puls;
    logic              venster;

    logic [DW:0]       r_sh;
    logic [DW:0]       f_ext;
    logic [WINDOW-1:0] p_div;
    logic [WINDOW-1:0] h;

    assign hs.Puls    = puls;
    assign hs.Tel     = tel;
    assign hs.Venster = venster;

    // Dividend is 2^WINDOW-1 (all ones), so every step shifts in a 1.
    always_comb begin
        r_sh  = {r, 1'b1};
        f_ext = (DW + 1)'(f);
        p_div = (q < TWO) ? TWO : q;
        h     = ((p - ONE) < PLEN) ? (p - ONE) : PLEN;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            w       <= '0;
            q       <= '0;
            p       <= '0;
            ph      <= '0;
            r       <= '0;
            f       <= '0;
            tel     <= '0;
            puls    <= 1'b0;
            venster <= 1'b0;
        end else if (!hs.Enable) begin
            state   <= IDLE;
            w       <= '0;
            puls    <= 1'b0;
            venster <= 1'b0;
        end else begin
            w       <= w + ONE;
            venster <= (w == '0);
            if (w == '0) begin
                f     <= hs.Freq;
                tel   <= '0;
                puls  <= 1'b0;
                r     <= '0;
                q     <= '0;
                ph    <= '0;
                state <= (hs.Freq != 8'd0) ? DELEN : WACHT;
            end else begin
                case (state)
                    DELEN: begin
                        if (w == W_FIN) begin
                            p     <= p_div;
                            puls  <= 1'b1;
                            tel   <= tel + 8'd1;
                            ph    <= ONE;
                            state <= ACTIEF;
                        end else if (r_sh >= f_ext) begin
                            r <= DW'(r_sh - f_ext);
                            q <= {q[WINDOW-2:0], 1'b1};
                        end else begin
                            r <= r_sh[DW-1:0];
                            q <= {q[WINDOW-2:0], 1'b0};
                        end
                    end
                    ACTIEF: begin
                        // ph counts cycles since the last rise; h < p keeps fall and rise apart.
                        if (ph == h) begin
                            puls <= 1'b0;
                            if (tel == f) state <= WACHT;
                        end
                        if (ph == p && tel != f) begin
                            puls <= 1'b1;
                            tel  <= tel + 8'd1;
                            ph   <= ONE;
                        end else begin
                            ph <= ph + ONE;
                        end
                    end
                    default: puls <= 1'b0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hartslag_generator.sv
// Bench for hartslag_generator: vector table, hand sequences, and randomized
// stimulus against a per-window pulse-schedule model.
module tb_hartslag_generator;
    localparam int WLEN = 256;
    localparam int LAT  = 9;
    localparam int PLEN = 4;

    logic CLK;
    logic Reset;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   check_on = 0;

    hartslag_generator_if hb ();

    hartslag_generator #(.WINDOW(8), .PULSE_LEN(PLEN)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .hs    (hb.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: pulse k of a window rises LAT edges after the window
    // start plus k periods; outputs follow from the edge offset alone.
    int m_pos = 0, m_f = 0, m_p = 2, m_h = 1, m_tel = 0, m_k;
    bit m_puls = 0, m_ven = 0;

    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            m_pos = 0; m_tel = 0; m_puls = 0; m_ven = 0;
        end else if (!hb.Enable) begin
            m_pos = 0; m_puls = 0; m_ven = 0;
        end else begin
            if (m_pos == 0) begin
                m_f = hb.Freq;
                m_p = (m_f == 0) ? 2 : (WLEN - 1) / m_f;
                if (m_p < 2) m_p = 2;
                m_h = (m_p - 1 < PLEN) ? m_p - 1 : PLEN;
            end
            m_ven = (m_pos == 0);
            if (m_f == 0 || m_pos < LAT) begin
                m_tel = 0; m_puls = 0;
            end else begin
                m_k    = (m_pos - LAT) / m_p;
                m_tel  = (m_k + 1 < m_f) ? m_k + 1 : m_f;
                m_puls = (m_k < m_f) && ((m_pos - LAT) % m_p < m_h);
            end
            m_pos = (m_pos + 1) % WLEN;
        end
        #1;
        if (check_on) begin
            chk("model_puls",    hb.Puls,    m_puls);
            chk("model_tel",     hb.Tel,     m_tel);
            chk("model_venster", hb.Venster, m_ven);
        end
    end

    task automatic fresh(input logic [7:0] f);
        Reset     = 1'b1;
        hb.Enable = 1'b0;
        hb.Freq   = f;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Reset     = 1'b0;
        hb.Enable = 1'b1;
    endtask

    typedef struct {
        logic [7:0] freq;
        int         pos;
        logic       puls;
        logic [7:0] tel;
        logic       ven;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc, vc;
        Reset = 1'b1; hb.Enable = 1'b0; hb.Freq = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_puls", hb.Puls, 0);
        chk("reset_tel", hb.Tel, 0);
        chk("reset_venster", hb.Venster, 0);
        check_on = 1;

        tbl.push_back('{8'd4,   0,   1'b0, 8'd0,   1'b1});
        tbl.push_back('{8'd4,   8,   1'b0, 8'd0,   1'b0});
        tbl.push_back('{8'd4,   9,   1'b1, 8'd1,   1'b0});
        tbl.push_back('{8'd4,   12,  1'b1, 8'd1,   1'b0});
        tbl.push_back('{8'd4,   13,  1'b0, 8'd1,   1'b0});
        tbl.push_back('{8'd4,   72,  1'b1, 8'd2,   1'b0});
        tbl.push_back('{8'd4,   198, 1'b1, 8'd4,   1'b0});
        tbl.push_back('{8'd4,   202, 1'b0, 8'd4,   1'b0});
        tbl.push_back('{8'd4,   255, 1'b0, 8'd4,   1'b0});
        tbl.push_back('{8'd200, 9,   1'b1, 8'd1,   1'b0});
        tbl.push_back('{8'd200, 10,  1'b0, 8'd1,   1'b0});
        tbl.push_back('{8'd200, 11,  1'b1, 8'd2,   1'b0});
        tbl.push_back('{8'd200, 254, 1'b0, 8'd123, 1'b0});
        tbl.push_back('{8'd200, 255, 1'b1, 8'd124, 1'b0});
        tbl.push_back('{8'd0,   100, 1'b0, 8'd0,   1'b0});
        tbl.push_back('{8'd1,   13,  1'b0, 8'd1,   1'b0});
        tbl.push_back('{8'd2,   136, 1'b1, 8'd2,   1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            fresh(tbl[i].freq);
            repeat (tbl[i].pos + 1) @(posedge CLK);
            #1;
            chk($sformatf("vec%0d_puls", i), hb.Puls, tbl[i].puls);
            chk($sformatf("vec%0d_tel", i), hb.Tel, tbl[i].tel);
            chk($sformatf("vec%0d_venster", i), hb.Venster, tbl[i].ven);
        end

        // Freq 4 -> 8 mid-window takes effect only at the next window.
        fresh(8'd4);
        repeat (100) @(posedge CLK);
        #1 hb.Freq = 8'd8;
        repeat (156) @(posedge CLK);
        #1 chk("fchg_tel_w1", hb.Tel, 4);
        repeat (227) @(posedge CLK);
        #1 chk("fchg_puls_226", hb.Puls, 1);
        chk("fchg_tel_226", hb.Tel, 8);
        repeat (29) @(posedge CLK);
        #1 chk("fchg_tel_w2", hb.Tel, 8);

        // Asynchronous reset during the second pulse.
        fresh(8'd4);
        repeat (74) @(posedge CLK);
        #1 chk("rst_pre_puls", hb.Puls, 1);
        chk("rst_pre_tel", hb.Tel, 2);
        #2 Reset = 1'b1;
        #1 chk("rst_async_puls", hb.Puls, 0);
        chk("rst_async_tel", hb.Tel, 0);
        chk("rst_async_venster", hb.Venster, 0);
        @(negedge CLK) Reset = 1'b0;
        @(posedge CLK);
        #1 chk("rst_restart_venster", hb.Venster, 1);
        repeat (9) @(posedge CLK);
        #1 chk("rst_first_puls", hb.Puls, 1);

        // Enable dropped at W=80, then re-enabled.
        fresh(8'd4);
        repeat (80) @(posedge CLK);
        #1 chk("en_pre_tel", hb.Tel, 2);
        hb.Enable = 1'b0;
        @(posedge CLK);
        #1 chk("en_off_puls", hb.Puls, 0);
        chk("en_off_tel_held", hb.Tel, 2);
        repeat (3) @(posedge CLK);
        #1 hb.Enable = 1'b1;
        @(posedge CLK);
        #1 chk("en_on_venster", hb.Venster, 1);
        chk("en_on_tel", hb.Tel, 0);
        repeat (8) @(posedge CLK);
        #1 chk("en_on_puls_early", hb.Puls, 0);
        @(posedge CLK);
        #1 chk("en_on_puls_9", hb.Puls, 1);

        // Freq=0 for three windows.
        fresh(8'd0);
        pc = 0; vc = 0;
        repeat (3 * WLEN) begin
            @(posedge CLK);
            #1;
            pc += int'(hb.Puls);
            vc += int'(hb.Venster);
        end
        chk("f0_puls_count", pc, 0);
        chk("f0_venster_count", vc, 3);
        chk("f0_tel", hb.Tel, 0);

        // Randomized run against the model.
        fresh(8'($urandom_range(1, 255)));
        for (int c = 0; c < 6000; c++) begin
            @(negedge CLK);
            Reset = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 3))
                    0:       hb.Freq = 8'd0;
                    1:       hb.Freq = 8'($urandom_range(1, 10));
                    2:       hb.Freq = 8'($urandom_range(1, 255));
                    default: hb.Freq = 8'($urandom_range(120, 255));
                endcase
            end
            if (hb.Enable) begin
                if ($urandom_range(0, 599) == 0) hb.Enable = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                hb.Enable = 1'b1;
            end
        end
        @(negedge CLK) Reset = 1'b0;
        @(posedge CLK);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
